// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - OV7670 frame capture sequencer (vsync/href alignment, counters)
// Optional geometry checking is compiled in with `define CAP_CHECK_EN.
module cam_capture_ctrl #(
    parameter int AW   = 17,
    parameter int H_PX = 160,
    parameter int V_LN = 120
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    output logic          cap_en,
    output logic          frame_start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] px_cnt,
    output logic [7:0]    line_cnt,
    output logic [7:0]    frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_VS    = 2'd1,
        S_WAIT_FRAME = 2'd2,
        S_CAPTURE    = 2'd3
    } state_t;

    localparam logic [AW-1:0] PX_MAX = '1;

    state_t          state_q, state_d;
    logic            vsync_q, href_q;
    logic            mode_q, mode_d;
    logic            byte_q, byte_d;
    logic            cap_en_q, cap_en_d;
    logic            frame_start_q, frame_start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [AW-1:0]   px_cnt_q, px_cnt_d;
    logic [7:0]      line_cnt_q, line_cnt_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
`ifdef CAP_CHECK_EN
    logic [AW-1:0]   line_px_q, line_px_d;
`endif

    logic vs_rise, vs_fall, hr_rise, hr_fall;
    logic start_ok, capturing, frame_end;

    assign vs_rise   = vsync & ~vsync_q;
    assign vs_fall   = ~vsync & vsync_q;
    assign hr_rise   = href & ~href_q;
    assign hr_fall   = ~href & href_q;
    assign start_ok  = (state_q == S_IDLE) && start && !abort;
    assign capturing = (state_q == S_CAPTURE) && !abort;
    assign frame_end = capturing && vs_rise;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            mode_q        <= 1'b0;
            byte_q        <= 1'b0;
            cap_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            px_cnt_q      <= '0;
            line_cnt_q    <= '0;
            frame_cnt_q   <= '0;
`ifdef CAP_CHECK_EN
            line_px_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync;
            href_q        <= href;
            mode_q        <= mode_d;
            byte_q        <= byte_d;
            cap_en_q      <= cap_en_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            px_cnt_q      <= px_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
`ifdef CAP_CHECK_EN
            line_px_q     <= line_px_d;
`endif
        end
    end

    // Abort outranks every transition, including a start in the same cycle.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:       if (start)   state_d = S_WAIT_VS;
                S_WAIT_VS:    if (vs_rise) state_d = S_WAIT_FRAME;
                S_WAIT_FRAME: if (vs_fall) state_d = S_CAPTURE;
                S_CAPTURE:    if (vs_rise) state_d = mode_q ? S_WAIT_FRAME : S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mode_d        = mode_q;
        byte_d        = byte_q;
        px_cnt_d      = px_cnt_q;
        line_cnt_d    = line_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        err_d         = err_q;
        cap_en_d      = (state_d == S_CAPTURE);
        busy_d        = (state_d != S_IDLE);
        frame_start_d = (state_q == S_WAIT_FRAME) && (state_d == S_CAPTURE);
        done_d        = frame_end;
`ifdef CAP_CHECK_EN
        line_px_d     = line_px_q;
`endif

        if (hr_fall || frame_start_d) begin
            byte_d = 1'b0;
        end

        // Bytes arrive in pairs; a pixel is counted when its second byte lands.
        if (capturing) begin
            if (href) begin
                byte_d = ~byte_q;
                if (byte_q && px_cnt_q != PX_MAX) begin
                    px_cnt_d = px_cnt_q + 1'b1;
                end
            end
            if (hr_fall && line_cnt_q != 8'hFF) begin
                line_cnt_d = line_cnt_q + 8'd1;
            end
        end

`ifdef CAP_CHECK_EN
        if (hr_rise) begin
            line_px_d = '0;
        end else if (capturing && href && byte_q && line_px_q != PX_MAX) begin
            line_px_d = line_px_q + 1'b1;
        end
        if (capturing && hr_fall && (line_px_q != AW'(H_PX) || byte_q)) begin
            err_d = 1'b1;
        end
        if (frame_end && line_cnt_q != 8'(V_LN)) begin
            err_d = 1'b1;
        end
`else
        err_d = 1'b0;
`endif

        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (mode_q) begin
                px_cnt_d   = '0;
                line_cnt_d = '0;
            end
        end

        if (start_ok) begin
            mode_d     = mode;
            byte_d     = 1'b0;
            px_cnt_d   = '0;
            line_cnt_d = '0;
            err_d      = 1'b0;
        end
    end

    assign cap_en      = cap_en_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign px_cnt      = px_cnt_q;
    assign line_cnt    = line_cnt_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - self-checking bench for cam_capture_ctrl with a frame-level reference model
module tb_cam_capture_ctrl;

    localparam int AW   = 17;
    localparam int H_PX = 16;
    localparam int V_LN = 10;
`ifdef CAP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          rst, vsync, href, start, mode, abort;
    logic          cap_en, frame_start, busy, done, err;
    logic [AW-1:0] px_cnt;
    logic [7:0]    line_cnt, frame_cnt;

    cam_capture_ctrl #(.AW(AW), .H_PX(H_PX), .V_LN(V_LN)) dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .start(start),
        .mode(mode), .abort(abort), .cap_en(cap_en), .frame_start(frame_start),
        .busy(busy), .done(done), .err(err), .px_cnt(px_cnt),
        .line_cnt(line_cnt), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    int lb[0:255];
    int exp_fc = 0;

    int n_done = 0, n_fs = 0, n_cap = 0;
    int q_px[$];
    int q_ln[$];
    bit q_err[$];
    int prev_px = 0, prev_ln = 0;

    // Per-frame record: counters as they stood the cycle before done, err as of done.
    always @(negedge pclk) begin
        if (done) begin
            q_px.push_back(prev_px);
            q_ln.push_back(prev_ln);
            q_err.push_back(err);
            n_done++;
        end
        if (frame_start) n_fs++;
        if (cap_en) n_cap++;
        prev_px = int'(px_cnt);
        prev_ln = int'(line_cnt);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic set_lines(input int nl);
        for (int i = 0; i < nl; i++) lb[i] = 2 * H_PX;
    endtask

    task automatic cam_frame(input int nl);
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < nl; i++) begin
            href = 1'b1;
            repeat (lb[i]) tick();
            href = 1'b0;
            repeat ($urandom_range(2, 5)) tick();
        end
        repeat (3) tick();
    endtask

    // Expected frame result straight from the line list: pixels are byte pairs,
    // any line not exactly 2*H_PX bytes or a wrong line count flags an error.
    function automatic void model(input int nl, output int epx, output bit eerr);
        epx  = 0;
        eerr = (nl != V_LN);
        for (int i = 0; i < nl; i++) begin
            epx += lb[i] / 2;
            if (lb[i] != 2 * H_PX) eerr = 1'b1;
        end
        if (!CHK) eerr = 1'b0;
    endfunction

    task automatic check_frame(input string nm, input int base_done, input int nl);
        int  epx;
        bit  eerr;
        model(nl, epx, eerr);
        total++;
        if (n_done - base_done !== 1) begin
            bad++; $display("FAIL %s_done_count got=%0d exp=1", nm, n_done - base_done);
        end else begin
            total += 3;
            if (q_px[n_done-1] !== epx) begin
                bad++; $display("FAIL %s_px got=%0d exp=%0d", nm, q_px[n_done-1], epx);
            end
            if (q_ln[n_done-1] !== nl) begin
                bad++; $display("FAIL %s_lines got=%0d exp=%0d", nm, q_ln[n_done-1], nl);
            end
            if (q_err[n_done-1] !== eerr) begin
                bad++; $display("FAIL %s_err got=%0d exp=%0d", nm, q_err[n_done-1], eerr);
            end
        end
        total++;
        if (frame_cnt !== 8'(exp_fc)) begin
            bad++; $display("FAIL %s_frame_cnt got=%0d exp=%0d", nm, frame_cnt, exp_fc);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s_busy_after got=%0d exp=0", nm, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; href = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        repeat (3) tick();
        total++;
        if ({cap_en, frame_start, busy, done, err} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {cap_en, frame_start, busy, done, err});
        end
        total++;
        if ({px_cnt, line_cnt, frame_cnt} !== '0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", px_cnt, line_cnt, frame_cnt);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int bd, bfs, bcap;
        set_lines(V_LN);
        bd = n_done; bfs = n_fs; bcap = n_cap;
        fork
            cam_frame(V_LN);
            begin
                repeat (15) tick();
                pulse_start(1'b0);
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL single_busy_rise got=%0d exp=1", busy);
                end
            end
        join
        total++;
        if (n_cap !== bcap) begin
            bad++; $display("FAIL single_no_early_cap got=%0d exp=%0d", n_cap, bcap);
        end
        cam_frame(V_LN);
        cam_frame(0);
        exp_fc++;
        check_frame("single", bd, V_LN);
        total++;
        if (n_fs - bfs !== 1) begin
            bad++; $display("FAIL single_frame_start got=%0d exp=1", n_fs - bfs);
        end
    endtask

    task automatic test_continuous();
        int bd;
        pulse_start(1'b1);
        bd = n_done;
        for (int f = 0; f < 3; f++) begin
            set_lines(V_LN);
            cam_frame(V_LN);
        end
        cam_frame(0);
        exp_fc += 3;
        total++;
        if (n_done - bd !== 3) begin
            bad++; $display("FAIL cont_done_count got=%0d exp=3", n_done - bd);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (q_px[bd+k] !== V_LN * H_PX || q_ln[bd+k] !== V_LN || q_err[bd+k] !== 1'b0) begin
                    bad++;
                    $display("FAIL cont_frame%0d got=%0d/%0d/%0d exp=%0d/%0d/0", k,
                             q_px[bd+k], q_ln[bd+k], q_err[bd+k], V_LN * H_PX, V_LN);
                end
            end
        end
        total++;
        if (frame_cnt !== 8'(exp_fc) || busy !== 1'b1) begin
            bad++; $display("FAIL cont_state got=%0d/%0d exp=%0d/1", frame_cnt, busy, exp_fc);
        end
        total++;
        if (px_cnt !== '0 || line_cnt !== 8'd0) begin
            bad++; $display("FAIL cont_rezero got=%0d/%0d exp=0/0", px_cnt, line_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || cap_en !== 1'b0) begin
            bad++; $display("FAIL cont_abort got=%0d/%0d exp=0/0", busy, cap_en);
        end
    endtask

    task automatic test_abort();
        int bd;
        int cyc;
        pulse_start(1'b0);
        set_lines(V_LN);
        bd = n_done;
        fork
            cam_frame(V_LN);
            begin
                cyc = 0;
                while (line_cnt !== 8'd3 && cyc < 3000) begin
                    tick();
                    cyc++;
                end
                total++;
                if (cyc >= 3000) begin
                    bad++; $display("FAIL abort_wait_timeout got=%0d exp=3", line_cnt);
                end
                abort = 1'b1;
                tick();
                abort = 1'b0;
                total++;
                if (cap_en !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL abort_next_cycle got=%0d/%0d exp=0/0", cap_en, busy);
                end
            end
        join
        cam_frame(0);
        total++;
        if (n_done !== bd || frame_cnt !== 8'(exp_fc)) begin
            bad++; $display("FAIL abort_no_done got=%0d/%0d exp=%0d/%0d", n_done, frame_cnt, bd, exp_fc);
        end
        total++;
        if (px_cnt !== AW'(3 * H_PX) || line_cnt !== 8'd3) begin
            bad++; $display("FAIL abort_hold got=%0d/%0d exp=%0d/3", px_cnt, line_cnt, 3 * H_PX);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL start_abort_same got=%0d exp=0", busy);
        end
    endtask

    task automatic test_geometry();
        int bd, nl, idx;
        for (int c = 0; c < 3; c++) begin
            pulse_start(1'b0);
            total++;
            if (err !== 1'b0) begin
                bad++; $display("FAIL geo%0d_err_clear got=%0d exp=0", c, err);
            end
            set_lines(V_LN);
            nl  = V_LN;
            idx = $urandom_range(0, V_LN - 1);
            if (c == 0) lb[idx] = 2 * H_PX - 2;
            else if (c == 1) lb[idx] = 2 * H_PX + 1;
            else nl = V_LN - 1;
            bd = n_done;
            cam_frame(nl);
            cam_frame(0);
            exp_fc++;
            check_frame($sformatf("geo%0d", c), bd, nl);
        end
    endtask

    task automatic test_random();
        int bd, nl, r;
        for (int it = 0; it < 5; it++) begin
            r  = $urandom_range(0, 3);
            nl = (r == 0) ? V_LN - 1 : (r == 3) ? V_LN + 1 : V_LN;
            for (int i = 0; i < nl; i++) begin
                lb[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(2 * H_PX - 3, 2 * H_PX + 2) : 2 * H_PX;
            end
            pulse_start(1'b0);
            bd = n_done;
            cam_frame(nl);
            cam_frame(0);
            exp_fc++;
            check_frame($sformatf("rand%0d", it), bd, nl);
        end
    endtask

    task automatic test_reset_mid();
        int bd, bcap, cyc;
        pulse_start(1'b0);
        set_lines(V_LN);
        bcap = 0;
        fork
            cam_frame(V_LN);
            begin
                cyc = 0;
                while (line_cnt !== 8'd2 && cyc < 3000) begin
                    tick();
                    cyc++;
                end
                #3 rst = 1'b1;
                #1;
                total++;
                if ({cap_en, frame_start, busy, done, err} !== 5'b0 ||
                    {px_cnt, line_cnt, frame_cnt} !== '0) begin
                    bad++;
                    $display("FAIL rst_mid_immediate got=%b/%0d/%0d/%0d exp=0",
                             {cap_en, frame_start, busy, done, err}, px_cnt, line_cnt, frame_cnt);
                end
                #2 rst = 1'b0;
                tick();
                bcap = n_cap;
                pulse_start(1'b0);
            end
        join
        exp_fc = 0;
        total++;
        if (n_cap !== bcap) begin
            bad++; $display("FAIL rst_mid_no_early_cap got=%0d exp=%0d", n_cap, bcap);
        end
        set_lines(V_LN);
        bd = n_done;
        cam_frame(V_LN);
        cam_frame(0);
        exp_fc++;
        check_frame("rst_rearm", bd, V_LN);
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_abort();
        test_geometry();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Frame-level sequencer for the OV7670 capture path. It arms capture on request and aligns it to the camera's frame boundaries (`vsync`/`href`). It gates the pixel-writing datapath through `cap_en`, counts pixels, lines and frames, and reports completion and geometry errors to the rest of the design. It sits between the user/control logic and the camera-read/frame-buffer write path, in the `pclk` domain.

## Interface
Parameters:
- `AW`, 17, pixel-address width; `px_cnt` width.
- `H_PX`, 160, expected pixels per line (2 bytes each).
- `V_LN`, 120, expected lines per frame.

Ports:
- `pclk`  in  1  camera pixel clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  camera frame sync, synchronous to `pclk`; high = vertical blanking.
- `href`  in  1  camera line valid, synchronous to `pclk`; one byte per cycle while high.
- `start`  in  1  capture request, sampled each cycle.
- `mode`  in  1  0 = single snapshot, 1 = continuous; sampled when `start` is accepted.
- `abort`  in  1  cancel capture.
- `cap_en`  out  1  enables the capture datapath and frame-buffer writes.
- `frame_start`  out  1  one-cycle pulse at the first cycle of an armed frame.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse per completed frame.
- `err`  out  1  sticky geometry error, cleared on accepted `start`.
- `px_cnt`  out  AW  pixels written in the current/last frame.
- `line_cnt`  out  8  lines in the current/last frame.
- `frame_cnt`  out  8  completed frames since reset, wraps 255→0.

## Operation
- Input registers: `vsync_q`, `href_q`. Edges are `vsync & ~vsync_q` and `href & ~href_q`, plus the corresponding falling edges.
- State machine states: IDLE, WAIT_VS, WAIT_FRAME, CAPTURE.
  - IDLE: accepting `start` (with `abort` low) latches `mode`, clears `px_cnt`/`line_cnt`/`err`, and moves to WAIT_VS.
  - WAIT_VS: on a `vsync` rising edge, go to WAIT_FRAME. A frame already in progress is never captured.
  - WAIT_FRAME: on a `vsync` falling edge, go to CAPTURE, assert `cap_en`, and pulse `frame_start`.
  - CAPTURE: on a `vsync` rising edge, deassert `cap_en`, pulse `done`, and increment `frame_cnt`.
    - If `mode` = 1, clear the counters and go to WAIT_FRAME.
    - Otherwise go to IDLE.
- Byte toggle: in CAPTURE, each `href`-high cycle flips a byte flag. `px_cnt` increments on every second byte. `px_cnt` saturates at 2^AW−1.
- Per-line pixel counter: cleared on an `href` rising edge.
  - On an `href` falling edge in CAPTURE, `line_cnt` increments; it saturates at 255.
  - The byte flag resets to 0 on an `href` falling edge.
- `abort` in any state: go to IDLE next cycle, `cap_en` low, no `done`, `frame_cnt` unchanged, counters hold.
- `start` while `busy` is ignored. When `start` and `abort` are asserted in the same cycle, `abort` wins.

## Timing
- Reset values: state IDLE; `cap_en`, `frame_start`, `busy`, `done`, `err` = 0; `px_cnt`, `line_cnt`, `frame_cnt` = 0; byte flag 0.
- All outputs are registered.
- Edge-detect latency: one cycle. `cap_en` rises in the cycle after the first `vsync`-low cycle, and the first `href` byte always follows it (OV7670 back porch ≥ 1 line).
- `done` and `cap_en` falling occur in the cycle after the `vsync` rising edge is sampled.
- `busy` rises in the cycle after `start` is accepted. In single mode, `busy` falls in the same cycle `done` is high.
- Reset mid-frame: immediate return to IDLE. The next capture again waits for a full `vsync` pulse.

## Configuration
- `CAP_CHECK_EN` defined: geometry checking is compiled in. `err` is set when any of these occur:
  - a line ends with a per-line pixel count ≠ `H_PX`;
  - a line ends with the byte flag = 1 (odd byte count);
  - a frame ends with `line_cnt` ≠ `V_LN`.
  - `err` stays set until the next accepted `start`; it does not affect sequencing or `done`.
- `CAP_CHECK_EN` undefined: no per-line pixel counter is built and `err` is tied to 0.

## Test plan
- Single snapshot of one 160×120 frame: pulse `start` mid-frame → no `cap_en` until the next full `vsync` pulse; then `frame_start` ×1, `px_cnt`=19200, `line_cnt`=120, `done` ×1, `frame_cnt`=1, `busy`=0, `err`=0.
- Continuous mode over 3 frames → 3 `done` pulses, `frame_cnt`=3, `busy` stays 1, counters re-zeroed each frame.
- `abort` asserted at line 50 → `cap_en`=0 and `busy`=0 in the next cycle, no `done`, `frame_cnt` unchanged; `start`+`abort` in the same cycle → stays IDLE.
- With `CAP_CHECK_EN`: one line of 159 pixels → `err`=1 after that line, `done` still pulses; a line of 321 bytes → `err`=1; a 119-line frame → `err`=1 at `done`; next `start` → `err`=0.
- `rst` asserted asynchronously mid-CAPTURE → all outputs at reset values immediately; capture re-arms only after a new `start` and a full `vsync` pulse.
